scan_for_test_if: RTL and testbench
===================================

# scan_for_test_if

Scan-chain bridge between the chip's scan pads and the on-chip SRAM port and control/status registers. A tester drives a serial chain through the pads. `scan_load_chip` issues SRAM and register commands from the chain. `scan_load_chain` captures read results back into the chain for shifting out. The block sits between the pad ring and the `spram` / `cs_reg` instances, and everything runs in the `clk` domain.

## Interface
- Parameters: none. Widths are fixed by the shared package.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous reset, active-high (asserted = 1 despite the suffix).
- `scan_id` in 1: chain select. 1 means this chain responds to the pads.
- `scan_phi`, `scan_phi_bar` in 1: two-phase non-overlapping scan clocks from the pads.
- `scan_data_in` in 1: serial in.
- `scan_data_out` out 1: serial out.
- `scan_load_chip` in 1: rising edge applies the chain's write fields to the chip.
- `scan_load_chain` in 1: rising edge captures chip state into the chain.
- `sram_ren`, `sram_wen` out 1: SRAM strobes.
- `sram_addr` out 11: SRAM address (used for both read and write).
- `sram_wdata` out 32: SRAM write data.
- `sram_rdata` in 32, `sram_ready` in 1: SRAM read data and completion.
- `reg_wen`, `reg_ren` out 1: register strobes.
- `cr_wdata` out 17: control register write data.
- `cr_rdata` in 17, `sr_rdata` in 15, `reg_ready` in 1: register read data and completion.

## Operation
- All five pad inputs pass through 2-flop synchronizers, then rising-edge detection. Nothing happens while `scan_id`=0; `scan_data_out` is then 0.
- Chain: 130-bit register `chain`, with `scan_data_out` = `chain[0]`.
  - phi rise: master bit captures `scan_data_in`.
  - phi_bar rise: `chain <= {master, chain[129:1]}`.
- Chain map, LSB first:
  - read fields: [31:0] sram_rdata, [32] sram_ready, [49:33] cr_rdata, [64:50] sr_rdata, [65] reg_ready.
  - write fields: [66] sram_ren, [67] sram_wen, [78:68] sram_addr, [110:79] sram_wdata, [111] reg_ren, [112] reg_wen, [129:113] cr_wdata.
- load_chip: `sram_addr`, `sram_wdata` and `cr_wdata` load from the chain and hold until the next load_chip. Each strobe whose chain bit is 1 pulses high for exactly one clk.
- Read holding: `sram_rdata` is latched on any cycle with `sram_ready`=1 and sets sticky `sram_done`. An SRAM strobe pulse clears `sram_done`. `cr_rdata`/`sr_rdata` and `reg_done` behave the same way with `reg_ready` and the register strobes.
- load_chain:
  - read fields <= held rdata and done flags.
  - write fields <= current output holding registers; strobe bits <= last issued strobe values.
- Priority when events coincide in one cycle: load_chip, then load_chain, then shift. Lower-priority events that cycle are dropped.

## Timing
- Pad edge to action: 3 clk cycles (2 synchronizer + 1 edge register).
- Pad high/low phases must each last at least 4 clk cycles.
- Strobe pulse: 1 clk, asserted on the action cycle.
- Reset: all outputs 0, chain, master bit, holding registers, done flags and synchronizers 0. Reset mid-shift discards partial chain content.
- No handshake back to the pads. The tester waits for completion by polling the done bits.

## Structure
- Package `scan_pkg`: `CHAIN_LEN`=130, all field widths and LSB offsets as localparams, and a packed struct for the write fields.
- Sub-module `scan_sync`: 2-flop synchronizer plus rising-edge pulse. Instantiate 5 times.

## Test plan
- Reset: hold `rst_n`=1 for 5 cycles, then release. All outputs 0, and shifting 130 bits out yields all zeros.
- Shift loopback: `scan_id`=1, shift in 130 bits of alternating 1/0, then shift 130 more bits. The same pattern appears on `scan_data_out` (first bit first).
- SRAM write then read:
  - write: chain with wen=1, addr=11'h005, wdata=32'hDEADBEEF, then load_chip. One-cycle `sram_wen`; addr and wdata held.
  - read: load_chip with ren=1, then load_chain and shift out. Chain[31:0]=32'hDEADBEEF, [32]=1.
- Register path:
  - load_chip with reg_wen=1, cr_wdata=17'h1ABCD gives one `reg_wen` pulse.
  - core drives sr=15'h4000; reg_ren, then load_chain. Chain [49:33]=17'h1ABCD, [64:50]=15'h4000, [65]=1.
- Deselect: `scan_id`=0 with phi toggling and load pulses. Chain and outputs unchanged, `scan_data_out`=0.
- Collision/reset: load_chip and load_chain edges in the same cycle means only load_chip acts. `rst_n` asserted mid-shift clears the chain to 0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared widths, chain layout and field structs for the scan-to-chip bridge.
// Chain bits [65:0] carry read results; bits [129:66] carry the command fields.
package scan_pkg;

  localparam int CHAIN_LEN   = 130;
  localparam int SRAM_DW     = 32;
  localparam int SRAM_AW     = 11;
  localparam int CR_W        = 17;
  localparam int SR_W        = 15;

  localparam int SRAM_RDATA_LSB = 0;
  localparam int SRAM_READY_BIT = 32;
  localparam int CR_RDATA_LSB   = 33;
  localparam int SR_RDATA_LSB   = 50;
  localparam int REG_READY_BIT  = 65;
  localparam int RD_W           = 66;

  localparam int SRAM_REN_BIT   = 66;
  localparam int SRAM_WEN_BIT   = 67;
  localparam int SRAM_ADDR_LSB  = 68;
  localparam int SRAM_WDATA_LSB = 79;
  localparam int REG_REN_BIT    = 111;
  localparam int REG_WEN_BIT    = 112;
  localparam int CR_WDATA_LSB   = 113;
  localparam int WR_W           = CHAIN_LEN - RD_W;

  // Declared MSB first so the struct overlays chain[129:66] directly.
  typedef struct packed {
    logic [CR_W-1:0]    cr_wdata;
    logic               reg_wen;
    logic               reg_ren;
    logic [SRAM_DW-1:0] sram_wdata;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_wen;
    logic               sram_ren;
  } wr_fields_t;

  typedef struct packed {
    logic               reg_ready;
    logic [SR_W-1:0]    sr_rdata;
    logic [CR_W-1:0]    cr_rdata;
    logic               sram_ready;
    logic [SRAM_DW-1:0] sram_rdata;
  } rd_fields_t;

endpackage

// File: rtl/scan_for_test_if_sync.sv
// Two-flop synchronizer followed by an edge register; rise is a one-clk pulse
// on the synchronized 0->1 transition.
module scan_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign level = sh_q[1];
  assign rise  = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/scan_for_test_if.sv
// Scan-chain bridge: shifts a 130-bit chain from the pads, issues SRAM and
// register commands from it, and captures held read results back into it.
module scan_for_test_if
  import scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               scan_id,
  input  logic               scan_phi,
  input  logic               scan_phi_bar,
  input  logic               scan_data_in,
  output logic               scan_data_out,
  input  logic               scan_load_chip,
  input  logic               scan_load_chain,
  output logic               sram_ren,
  output logic               sram_wen,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  input  logic               sram_ready,
  output logic               reg_wen,
  output logic               reg_ren,
  output logic [CR_W-1:0]    cr_wdata,
  input  logic [CR_W-1:0]    cr_rdata,
  input  logic [SR_W-1:0]    sr_rdata,
  input  logic               reg_ready
);

  localparam int NPAD = 5;

  logic [NPAD-1:0] pad_in, pad_lvl, pad_rise;
  logic            unused_sync;

  assign pad_in = {scan_load_chain, scan_load_chip, scan_phi_bar, scan_phi, scan_id};

  for (genvar i = 0; i < NPAD; i++) begin : g_sync
    scan_sync u_sync (
      .clk  (clk),
      .rst  (rst_n),
      .d    (pad_in[i]),
      .level(pad_lvl[i]),
      .rise (pad_rise[i])
    );
  end

  assign unused_sync = ^{pad_lvl[NPAD-1:1], pad_rise[0]};

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic                 master_q, master_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [SRAM_DW-1:0]   wdata_q, wdata_d;
  logic [CR_W-1:0]      crw_q, crw_d;
  logic [3:0]           strobe_q, strobe_d;   // {reg_wen, reg_ren, sram_wen, sram_ren}
  logic [3:0]           last_q, last_d;
  logic [SRAM_DW-1:0]   sram_rd_q, sram_rd_d;
  logic                 sram_done_q, sram_done_d;
  logic [CR_W-1:0]      cr_rd_q, cr_rd_d;
  logic [SR_W-1:0]      sr_rd_q, sr_rd_d;
  logic                 reg_done_q, reg_done_d;

  logic       sel, chip_ev, chain_ev, low_ok;
  wr_fields_t wr_in, wr_hold;
  rd_fields_t rd_hold;

  assign wr_in = wr_fields_t'(chain_q[CHAIN_LEN-1:RD_W]);

  always_comb begin
    sel      = pad_lvl[0];
    chip_ev  = sel & pad_rise[3];
    chain_ev = sel & pad_rise[4] & ~pad_rise[3];
    low_ok   = sel & ~pad_rise[3] & ~pad_rise[4];

    wr_hold.cr_wdata   = crw_q;
    wr_hold.reg_wen    = last_q[3];
    wr_hold.reg_ren    = last_q[2];
    wr_hold.sram_wdata = wdata_q;
    wr_hold.sram_addr  = addr_q;
    wr_hold.sram_wen   = last_q[1];
    wr_hold.sram_ren   = last_q[0];

    rd_hold.reg_ready  = reg_done_q;
    rd_hold.sr_rdata   = sr_rd_q;
    rd_hold.cr_rdata   = cr_rd_q;
    rd_hold.sram_ready = sram_done_q;
    rd_hold.sram_rdata = sram_rd_q;

    chain_d  = chain_q;
    master_d = master_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    crw_d    = crw_q;
    strobe_d = '0;
    last_d   = last_q;

    if (chip_ev) begin
      addr_d   = wr_in.sram_addr;
      wdata_d  = wr_in.sram_wdata;
      crw_d    = wr_in.cr_wdata;
      strobe_d = {wr_in.reg_wen, wr_in.reg_ren, wr_in.sram_wen, wr_in.sram_ren};
      last_d   = strobe_d;
    end else if (chain_ev) begin
      chain_d = {wr_hold, rd_hold};
    end else if (low_ok) begin
      // scan_data_in is stable for several clks around the synchronized phi edge
      if (pad_rise[1]) master_d = scan_data_in;
      if (pad_rise[2]) chain_d  = {master_q, chain_q[CHAIN_LEN-1:1]};
    end

    // A new completion wins over the clear from the strobe that requested it.
    sram_rd_d   = sram_rd_q;
    sram_done_d = sram_done_q;
    if (sram_ready) begin
      sram_rd_d   = sram_rdata;
      sram_done_d = 1'b1;
    end else if (strobe_q[1] | strobe_q[0]) begin
      sram_done_d = 1'b0;
    end

    cr_rd_d    = cr_rd_q;
    sr_rd_d    = sr_rd_q;
    reg_done_d = reg_done_q;
    if (reg_ready) begin
      cr_rd_d    = cr_rdata;
      sr_rd_d    = sr_rdata;
      reg_done_d = 1'b1;
    end else if (strobe_q[3] | strobe_q[2]) begin
      reg_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      chain_q     <= '0;
      master_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      crw_q       <= '0;
      strobe_q    <= '0;
      last_q      <= '0;
      sram_rd_q   <= '0;
      sram_done_q <= 1'b0;
      cr_rd_q     <= '0;
      sr_rd_q     <= '0;
      reg_done_q  <= 1'b0;
    end else begin
      chain_q     <= chain_d;
      master_q    <= master_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      crw_q       <= crw_d;
      strobe_q    <= strobe_d;
      last_q      <= last_d;
      sram_rd_q   <= sram_rd_d;
      sram_done_q <= sram_done_d;
      cr_rd_q     <= cr_rd_d;
      sr_rd_q     <= sr_rd_d;
      reg_done_q  <= reg_done_d;
    end
  end

  assign scan_data_out = pad_lvl[0] & chain_q[0];
  assign sram_ren      = strobe_q[0];
  assign sram_wen      = strobe_q[1];
  assign reg_ren       = strobe_q[2];
  assign reg_wen       = strobe_q[3];
  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign cr_wdata      = crw_q;

endmodule

// File: tb/tb_scan_for_test_if.sv
// Directed bench for scan_for_test_if with a behavioural SRAM / register model.
module tb_scan_for_test_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        scan_id = 1'b0, scan_phi = 1'b0, scan_phi_bar = 1'b0, scan_data_in = 1'b0;
  logic        scan_load_chip = 1'b0, scan_load_chain = 1'b0;
  logic        scan_data_out;
  logic        sram_ren, sram_wen, reg_wen, reg_ren;
  logic [10:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;
  logic [16:0] cr_wdata;
  logic [16:0] cr_rdata = '0;
  logic [14:0] sr_rdata = '0;
  logic        reg_ready = 1'b0;

  logic [31:0] mem [0:2047];
  logic [16:0] cr_store = '0;
  logic [14:0] sr_val = '0;

  int n_tests = 0, n_fail = 0;
  int sram_wen_cnt = 0, sram_ren_cnt = 0, reg_wen_cnt = 0, reg_ren_cnt = 0;

  scan_for_test_if dut (
    .clk(clk), .rst_n(rst_n), .scan_id(scan_id), .scan_phi(scan_phi),
    .scan_phi_bar(scan_phi_bar), .scan_data_in(scan_data_in),
    .scan_data_out(scan_data_out), .scan_load_chip(scan_load_chip),
    .scan_load_chain(scan_load_chain), .sram_ren(sram_ren), .sram_wen(sram_wen),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ready(sram_ready), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .cr_wdata(cr_wdata), .cr_rdata(cr_rdata), .sr_rdata(sr_rdata), .reg_ready(reg_ready)
  );

  always #5 clk = ~clk;

  // Memory / register model: answers one cycle after a strobe.
  always @(posedge clk) begin
    sram_ready <= 1'b0;
    reg_ready  <= 1'b0;
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) begin
      sram_rdata <= mem[sram_addr];
      sram_ready <= 1'b1;
    end
    if (reg_wen) cr_store <= cr_wdata;
    if (reg_ren) begin
      cr_rdata  <= cr_store;
      sr_rdata  <= sr_val;
      reg_ready <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (sram_wen) sram_wen_cnt <= sram_wen_cnt + 1;
    if (sram_ren) sram_ren_cnt <= sram_ren_cnt + 1;
    if (reg_wen)  reg_wen_cnt  <= reg_wen_cnt + 1;
    if (reg_ren)  reg_ren_cnt  <= reg_ren_cnt + 1;
  end

  task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic d, output logic q);
    q = scan_data_out;
    scan_data_in = d;
    scan_phi = 1'b1;     tick(4);
    scan_phi = 1'b0;     tick(4);
    scan_phi_bar = 1'b1; tick(4);
    scan_phi_bar = 1'b0; tick(4);
  endtask

  task automatic shift_chain(input logic [129:0] din, output logic [129:0] dout);
    logic b;
    dout = '0;
    for (int i = 0; i < 130; i++) begin
      shift_bit(din[i], b);
      dout[i] = b;
    end
  endtask

  task automatic do_load(input logic chip, input logic chn);
    scan_load_chip  = chip;
    scan_load_chain = chn;
    tick(4);
    scan_load_chip  = 1'b0;
    scan_load_chain = 1'b0;
    tick(4);
  endtask

  initial begin
    logic [129:0] v, dout, pat;
    logic b;
    int w0, r0, rw0, rr0;

    rst_n = 1'b1;
    tick(5);
    rst_n = 1'b0;
    tick(2);
    check("rst_strobes", 130'({sram_ren, sram_wen, reg_ren, reg_wen}), '0);
    check("rst_sram_addr", 130'(sram_addr), '0);
    check("rst_sram_wdata", 130'(sram_wdata), '0);
    check("rst_cr_wdata", 130'(cr_wdata), '0);
    scan_id = 1'b1;
    tick(5);
    shift_chain('0, dout);
    check("rst_chain", dout, '0);

    // Loopback of alternating 1/0, first bit 1
    pat = {65{2'b01}};
    shift_chain(pat, dout);
    shift_chain('0, dout);
    check("loopback", dout, pat);

    // SRAM write
    v = '0;
    v[67] = 1'b1;
    v[78:68] = 11'h005;
    v[110:79] = 32'hDEADBEEF;
    shift_chain(v, dout);
    w0 = sram_wen_cnt; r0 = sram_ren_cnt;
    do_load(1'b1, 1'b0);
    check("sram_wen_pulse", 130'(sram_wen_cnt - w0), 130'd1);
    check("sram_ren_idle", 130'(sram_ren_cnt - r0), '0);
    check("sram_addr_held", 130'(sram_addr), 130'h005);
    check("sram_wdata_held", 130'(sram_wdata), 130'hDEADBEEF);

    // SRAM read back
    v = '0;
    v[66] = 1'b1;
    v[78:68] = 11'h005;
    shift_chain(v, dout);
    r0 = sram_ren_cnt;
    do_load(1'b1, 1'b0);
    check("sram_ren_pulse", 130'(sram_ren_cnt - r0), 130'd1);
    do_load(1'b0, 1'b1);
    shift_chain('0, dout);
    check("rd_sram_rdata", 130'(dout[31:0]), 130'hDEADBEEF);
    check("rd_sram_done", 130'(dout[32]), 130'd1);
    check("rd_reg_fields", 130'(dout[65:33]), '0);
    check("rd_last_strobes", 130'(dout[67:66]), 130'b01);
    check("rd_addr_field", 130'(dout[78:68]), 130'h005);

    // Register write
    v = '0;
    v[112] = 1'b1;
    v[129:113] = 17'h1ABCD;
    shift_chain(v, dout);
    rw0 = reg_wen_cnt;
    do_load(1'b1, 1'b0);
    check("reg_wen_pulse", 130'(reg_wen_cnt - rw0), 130'd1);
    check("cr_wdata_held", 130'(cr_wdata), 130'h1ABCD);

    // Register read
    sr_val = 15'h4000;
    v = '0;
    v[111] = 1'b1;
    v[129:113] = 17'h1ABCD;
    shift_chain(v, dout);
    rr0 = reg_ren_cnt;
    do_load(1'b1, 1'b0);
    check("reg_ren_pulse", 130'(reg_ren_cnt - rr0), 130'd1);
    do_load(1'b0, 1'b1);
    shift_chain('0, dout);
    check("rd_cr", 130'(dout[49:33]), 130'h1ABCD);
    check("rd_sr", 130'(dout[64:50]), 130'h4000);
    check("rd_reg_done", 130'(dout[65]), 130'd1);
    check("rd_sram_done_kept", 130'(dout[32]), 130'd1);
    check("rd_reg_last", 130'(dout[112:111]), 130'b01);

    // Deselect: chain, strobes and outputs frozen
    pat = {64'hA5C3_0F0F_1234_8765, 66'h2_F0E1_D2C3_B4A5_9687};
    shift_chain(pat, dout);
    w0 = sram_wen_cnt + sram_ren_cnt + reg_wen_cnt + reg_ren_cnt;
    scan_id = 1'b0;
    tick(5);
    check("desel_sdo", 130'(scan_data_out), '0);
    for (int i = 0; i < 3; i++) shift_bit(1'b1, b);
    do_load(1'b1, 1'b0);
    do_load(1'b0, 1'b1);
    check("desel_sdo_after", 130'(scan_data_out), '0);
    check("desel_strobes", 130'(sram_wen_cnt + sram_ren_cnt + reg_wen_cnt + reg_ren_cnt - w0), '0);
    check("desel_cr_wdata", 130'(cr_wdata), 130'h1ABCD);
    scan_id = 1'b1;
    tick(5);
    shift_chain('0, dout);
    check("desel_chain", dout, pat);

    // Collision: load_chip and load_chain together, only load_chip acts
    v = '0;
    v[65:0] = 66'h1_5555_AAAA_0F0F_3C3C;
    v[67] = 1'b1;
    v[78:68] = 11'h12A;
    v[110:79] = 32'h12345678;
    shift_chain(v, dout);
    w0 = sram_wen_cnt;
    do_load(1'b1, 1'b1);
    check("coll_wen_pulse", 130'(sram_wen_cnt - w0), 130'd1);
    check("coll_addr", 130'(sram_addr), 130'h12A);
    shift_chain('0, dout);
    check("coll_chain", dout, v);

    // Reset in the middle of a shift
    for (int i = 0; i < 60; i++) shift_bit(1'b1, b);
    rst_n = 1'b1;
    tick(3);
    rst_n = 1'b0;
    tick(5);
    check("rstmid_addr", 130'(sram_addr), '0);
    check("rstmid_wdata", 130'(sram_wdata), '0);
    check("rstmid_cr", 130'(cr_wdata), '0);
    shift_chain('0, dout);
    check("rstmid_chain", dout, '0);
    do_load(1'b0, 1'b1);
    shift_chain('0, dout);
    check("rstmid_capture", dout, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
